// File: rtl/adder_chunked.sv
// -----------------------------------------------------------------------------
// adder_chunked
//   Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock.
//   A ripple carry is kept in a register between chunks. Subtraction uses the
//   identity a - b - cin == a + ~b + ~cin, so the same adder serves both modes.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     in_valid   operand pair and mode bits are valid
//     in_ready   block can accept operands (registered)
//     a, b       WIDTH-bit operands
//     cin        carry-in (add) / borrow-in (subtract)
//     sub        0: a+b+cin, 1: a-b-cin
//     out_valid  result valid and held until out_ready (registered)
//     out_ready  consumer accepts the result
//     sum        result modulo 2^WIDTH
//     cout       carry out of the MSB; in subtract mode 1 means "no borrow"
//     ovf        two's-complement signed overflow
//
//   WIDTH must be a multiple of CHUNK. Latency from accept to out_valid is
//   WIDTH/CHUNK cycles.
// -----------------------------------------------------------------------------
module adder_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide so NCHUNK == 1 still elaborates.
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted when subtracting
  logic             c_q;      // inter-chunk carry
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_next;

  // One CHUNK-bit slice of the ripple adder, selected by the chunk index.
  // NOTE: every signal driven here is assigned on every path, so the block is
  // purely combinational; a missing assignment would infer a latch.
  always_comb begin
    a_chunk = a_q[k*CHUNK +: CHUNK];
    b_chunk = b_q[k*CHUNK +: CHUNK];
    {c_next, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      k         <= '0;
      c_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            c_q      <= sub ? ~cin : cin;
            k        <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          sum[k*CHUNK +: CHUNK] <= s_chunk;
          c_q                   <= c_next;
          if (k == K_LAST) begin
            k         <= '0;
            cout      <= c_next;
            // Signed overflow: operands (as fed to the adder) agree in sign
            // but the result sign differs.
            ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: a_q and b_q are deliberately left out of reset: they are only read
  // in RUN, which is always entered through a capture that loads them.

endmodule

// File: tb/tb_adder_chunked.sv
// -----------------------------------------------------------------------------
// tb_adder_chunked
//   Self-checking bench for adder_chunked. Four instances cover the
//   configurations (8,4), (16,1), (16,4) and (16,16); they share operand and
//   handshake wires, and in_valid is steered to the selected instance only.
//   Expected results come from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_adder_chunked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_d;
  logic        out_ready;
  logic        cin_d;
  logic        sub_d;
  logic [15:0] a_d;
  logic [15:0] b_d;
  int          sel;

  logic        in_valid_v  [4];
  logic        in_ready_v  [4];
  logic        out_valid_v [4];
  logic        cout_v      [4];
  logic        ovf_v       [4];
  logic [15:0] sum_v       [4];
  logic [7:0]  sum8;

  int checks = 0;
  int errors = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) in_valid_v[i] = in_valid_d && (sel == i);
  end

  assign sum_v[0] = {8'h00, sum8};

  adder_chunked #(.WIDTH(8), .CHUNK(4)) u_w8_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .sum(sum8), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  adder_chunked #(.WIDTH(16), .CHUNK(1)) u_w16_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  adder_chunked #(.WIDTH(16), .CHUNK(4)) u_w16_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  adder_chunked #(.WIDTH(16), .CHUNK(16)) u_w16_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3])
  );

  function automatic int w_of(input int idx);
    return (idx == 0) ? 8 : 16;
  endfunction

  function automatic int c_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  // Reference: exact integer arithmetic, then reduce to WIDTH bits.
  function automatic void model(input int w, input longint av, input longint bv,
                                input longint cv, input bit sv,
                                output longint es, output longint ec,
                                output longint eo);
    longint m, half, sa, sb, ru, rs;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (av >= half) ? av - (m + 1) : av;
    sb   = (bv >= half) ? bv - (m + 1) : bv;
    if (!sv) begin
      ru = av + bv + cv;
      ec = (ru > m) ? 1 : 0;
      rs = sa + sb + cv;
    end else begin
      ru = av - bv - cv;
      ec = (av >= bv + cv) ? 1 : 0;   // no borrow
      rs = sa - sb - cv;
    end
    es = ru & m;
    eo = (rs >= half || rs < -half) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance idx, with optional random backpressure.
  task automatic do_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic sv, input bit rnd_bp,
                       output logic [15:0] gs, output logic gc, output logic go);
    int          w;
    int          n;
    int          lat;
    bit          go_now;
    bit          done;
    logic [15:0] mask;
    longint      es, ec, eo;
    w    = w_of(idx);
    n    = w / c_of(idx);
    mask = 16'((32'd1 << w) - 1);
    av   = av & mask;
    bv   = bv & mask;
    model(w, longint'(av), longint'(bv), longint'(cv), sv, es, ec, eo);

    sel = idx;
    check("ready_before_accept", 64'(in_ready_v[idx]), 64'd1);
    a_d = av; b_d = bv; cin_d = cv; sub_d = sv;
    in_valid_d = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    check("ready_low_after_accept", 64'(in_ready_v[idx]), 64'd0);

    // Scramble operands while running: they must not affect the result.
    lat = 0;
    while (out_valid_v[idx] !== 1'b1 && lat < 40) begin
      a_d = 16'($urandom); b_d = 16'($urandom);
      cin_d = 1'($urandom); sub_d = 1'($urandom);
      out_ready = rnd_bp ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(n));
    gs = sum_v[idx];
    gc = cout_v[idx];
    go = ovf_v[idx];
    check("sum_vs_model",  64'(gs), 64'(es));
    check("cout_vs_model", 64'(gc), 64'(ec));
    check("ovf_vs_model",  64'(go), 64'(eo));

    done = 1'b0;
    lat  = 0;
    while (!done && lat < 40) begin
      go_now = (rnd_bp && lat < 8) ? ($urandom_range(0, 2) == 0) : 1'b1;
      out_ready = go_now;
      if (!go_now) begin
        a_d = 16'($urandom); b_d = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (go_now) begin
        done = 1'b1;
      end else begin
        check("held_valid", 64'(out_valid_v[idx]), 64'd1);
        check("held_sum",   64'(sum_v[idx]), 64'(gs));
        check("held_cout",  64'(cout_v[idx]), 64'(gc));
        check("held_ovf",   64'(ovf_v[idx]), 64'(go));
        check("held_ready", 64'(in_ready_v[idx]), 64'd0);
      end
    end
    out_ready = 1'b0;
    check("valid_low_after_xfer", 64'(out_valid_v[idx]), 64'd0);
    check("ready_high_after_xfer", 64'(in_ready_v[idx]), 64'd1);
  endtask

  logic [15:0] gs;
  logic        gc, go;
  int          lat;
  bit          rose;

  initial begin
    rst = 1'b1; in_valid_d = 1'b0; out_ready = 1'b0;
    cin_d = 1'b0; sub_d = 1'b0; a_d = '0; b_d = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("reset_in_ready",  64'(in_ready_v[i]), 64'd1);
      check("reset_out_valid", 64'(out_valid_v[i]), 64'd0);
      check("reset_sum",       64'(sum_v[i]), 64'd0);
      check("reset_cout",      64'(cout_v[i]), 64'd0);
      check("reset_ovf",       64'(ovf_v[i]), 64'd0);
    end

    // Directed cases, WIDTH=8 CHUNK=4.
    do_op(0, 16'h03, 16'h05, 1'b0, 1'b0, 1'b0, gs, gc, go);
    check("add_03_05_sum", 64'(gs), 64'h08);
    check("add_03_05_cout", 64'(gc), 64'd0);
    check("add_03_05_ovf", 64'(go), 64'd0);
    do_op(0, 16'hFF, 16'h01, 1'b1, 1'b0, 1'b0, gs, gc, go);
    check("add_ff_01_c1_sum", 64'(gs), 64'h01);
    check("add_ff_01_c1_cout", 64'(gc), 64'd1);
    check("add_ff_01_c1_ovf", 64'(go), 64'd0);
    do_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b0, gs, gc, go);
    check("add_7f_01_sum", 64'(gs), 64'h80);
    check("add_7f_01_cout", 64'(gc), 64'd0);
    check("add_7f_01_ovf", 64'(go), 64'd1);
    do_op(0, 16'h10, 16'h01, 1'b0, 1'b1, 1'b0, gs, gc, go);
    check("sub_10_01_sum", 64'(gs), 64'h0F);
    check("sub_10_01_cout", 64'(gc), 64'd1);
    check("sub_10_01_ovf", 64'(go), 64'd0);
    do_op(0, 16'h80, 16'h01, 1'b0, 1'b1, 1'b0, gs, gc, go);
    check("sub_80_01_sum", 64'(gs), 64'h7F);
    check("sub_80_01_cout", 64'(gc), 64'd1);
    check("sub_80_01_ovf", 64'(go), 64'd1);
    do_op(0, 16'h00, 16'h00, 1'b1, 1'b1, 1'b0, gs, gc, go);
    check("sub_00_00_b1_sum", 64'(gs), 64'hFF);
    check("sub_00_00_b1_cout", 64'(gc), 64'd0);
    check("sub_00_00_b1_ovf", 64'(go), 64'd0);

    // Backpressure: result frozen while out_ready is low and in_valid toggles.
    sel = 0;
    a_d = 16'h12; b_d = 16'h34; cin_d = 1'b0; sub_d = 1'b0;
    in_valid_d = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    lat = 0;
    while (out_valid_v[0] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd2);
    check("bp_sum", 64'(sum_v[0]), 64'h46);
    for (int i = 0; i < 5; i++) begin
      a_d = 16'($urandom); b_d = 16'($urandom);
      in_valid_d = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_frozen_sum", 64'(sum_v[0]), 64'h46);
      check("bp_frozen_valid", 64'(out_valid_v[0]), 64'd1);
      check("bp_ready_low", 64'(in_ready_v[0]), 64'd0);
    end
    in_valid_d = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_xfer_valid_low", 64'(out_valid_v[0]), 64'd0);
    check("bp_xfer_ready_high", 64'(in_ready_v[0]), 64'd1);
    @(posedge clk); #1;
    check("bp_single_transfer", 64'(out_valid_v[0]), 64'd0);

    // Reset while a result is pending in DONE.
    sel = 0;
    a_d = 16'h55; b_d = 16'h66; in_valid_d = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_before_reset", 64'(out_valid_v[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("done_reset_valid", 64'(out_valid_v[0]), 64'd0);
    check("done_reset_ready", 64'(in_ready_v[0]), 64'd1);
    check("done_reset_sum", 64'(sum_v[0]), 64'd0);
    check("done_reset_cout", 64'(cout_v[0]), 64'd0);

    // Reset mid-RUN on (16,4): operation aborted, no result ever appears.
    sel = 2;
    a_d = 16'hFFFF; b_d = 16'h0001; cin_d = 1'b0; sub_d = 1'b0;
    in_valid_d = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("run_reset_ready", 64'(in_ready_v[2]), 64'd1);
    check("run_reset_valid", 64'(out_valid_v[2]), 64'd0);
    check("run_reset_sum", 64'(sum_v[2]), 64'd0);
    check("run_reset_ovf", 64'(ovf_v[2]), 64'd0);
    rose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid_v[2] === 1'b1) rose = 1'b1;
    end
    check("run_reset_no_valid", 64'(rose), 64'd0);
    out_ready = 1'b0;

    // Random sweep over (16,1), (16,4), (16,16).
    for (int idx = 1; idx < 4; idx++) begin
      for (int v = 0; v < 200; v++) begin
        do_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              1'b1, gs, gc, go);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
